// File: rtl/run_controller_pkg.sv
// Shared types and default widths for the run controller and the CPU top level.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_e;

  localparam int DEF_NUM_PROGS = 4;
  localparam int IDX_W         = $clog2(DEF_NUM_PROGS);
  localparam int DEF_PC_W      = 8;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/run_controller_if.sv
// Host-side bus of the run controller: table config, run control, CPU hooks, status.
// Handshake: start is a level sampled only in IDLE/DONE, no ready; abort and cpu_halt are
// levels sampled only in RUN; status outputs are valid every cycle.
interface run_controller_if #(
  parameter int NUM_PROGS = 4,
  parameter int PC_W      = 8,
  parameter int CNT_W     = 16
);
  import run_ctrl_pkg::*;

  localparam int IW = $clog2(NUM_PROGS);

  logic             cfg_we;
  logic [IW-1:0]    cfg_idx;
  logic [PC_W-1:0]  cfg_pc;
  logic             start;
  logic [IW-1:0]    prog_sel;
  logic             abort;
  logic             cpu_halt;
  logic             cpu_init;
  logic [PC_W-1:0]  start_pc;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  run_state_e       dbg_state;

  modport master (
    output cfg_we, cfg_idx, cfg_pc, start, prog_sel, abort, cpu_halt,
    input  cpu_init, start_pc, busy, done, timeout, cycle_count, dbg_state
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_pc, start, prog_sel, abort, cpu_halt,
    output cpu_init, start_pc, busy, done, timeout, cycle_count, dbg_state
  );

endinterface

// File: rtl/run_controller_prog_pc_table.sv
// Start-PC register file: synchronous write, combinational read, cleared by reset.
module prog_pc_table #(
  parameter int NUM_PROGS = 4,
  parameter int PC_W      = 8,
  localparam int IW       = $clog2(NUM_PROGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [IW-1:0]   waddr_i,
  input  logic [PC_W-1:0] wdata_i,
  input  logic [IW-1:0]   raddr_i,
  output logic [PC_W-1:0] rdata_o
);

  logic [PC_W-1:0] mem_q [NUM_PROGS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PROGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read sees the pre-write value, so a same-cycle write never leaks into a start.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/run_controller.sv
// Holds the CPU in init, loads a start PC from the table, then counts RUN cycles until halt/timeout.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int NUM_PROGS   = DEF_NUM_PROGS,
  parameter int PC_W        = DEF_PC_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 1000
) (
  input logic            CLK,
  input logic            init,
  run_controller_if.slave bus
);

  localparam int IC_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  run_state_e       state_q;
  logic [PC_W-1:0]  start_pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [IC_W-1:0]  init_cnt_q;
  logic             done_q;
  logic             timeout_q;
  logic [PC_W-1:0]  tbl_rdata;

  prog_pc_table #(
    .NUM_PROGS(NUM_PROGS),
    .PC_W     (PC_W)
  ) u_table (
    .clk_i  (CLK),
    .rst_i  (init),
    .we_i   (bus.cfg_we),
    .waddr_i(bus.cfg_idx),
    .wdata_i(bus.cfg_pc),
    .raddr_i(bus.prog_sel),
    .rdata_o(tbl_rdata)
  );

  // Saturating increment; the watchdog normally fires long before all-ones.
  assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (init) begin
      state_q    <= IDLE;
      start_pc_q <= '0;
      cnt_q      <= '0;
      init_cnt_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            start_pc_q <= tbl_rdata;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            init_cnt_q <= IC_W'(INIT_CYCLES - 1);
            state_q    <= INIT;
          end
        end
        INIT: begin
          if (init_cnt_q == '0) state_q <= RUN;
          else                  init_cnt_q <= init_cnt_q - 1'b1;
        end
        RUN: begin
          cnt_q <= cnt_d;
          // abort beats halt, halt beats the watchdog in the same cycle
          if (bus.abort) begin
            state_q <= IDLE;
          end else if (bus.cpu_halt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cpu_init    = (state_q != RUN);
  assign bus.busy        = (state_q == INIT) || (state_q == RUN);
  assign bus.start_pc    = start_pc_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cnt_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: directed scenarios plus randomized runs vs. a run-level model.
module tb_run_controller;
  import run_ctrl_pkg::*;

  localparam int NP = 4;
  localparam int PW = 8;
  localparam int CW = 16;
  localparam int IC = 2;
  localparam int TO = 20;
  localparam int IW = $clog2(NP);

  logic CLK = 1'b0;
  logic init;
  always #5 CLK = ~CLK;

  run_controller_if #(.NUM_PROGS(NP), .PC_W(PW), .CNT_W(CW)) bus ();

  run_controller #(
    .NUM_PROGS  (NP),
    .PC_W       (PW),
    .CNT_W      (CW),
    .INIT_CYCLES(IC),
    .TIMEOUT    (TO)
  ) dut (
    .CLK (CLK),
    .init(init),
    .bus (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [PW-1:0] exp_tbl [NP];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_quiet();
    bus.cfg_we   = 1'b0;
    bus.cfg_idx  = '0;
    bus.cfg_pc   = '0;
    bus.start    = 1'b0;
    bus.prog_sel = '0;
    bus.abort    = 1'b0;
    bus.cpu_halt = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input logic [PW-1:0] pc);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = IW'(idx);
    bus.cfg_pc  = pc;
    step();
    bus.cfg_we  = 1'b0;
    exp_tbl[idx] = pc;
  endtask

  // One complete run; the expected end is derived from the halt/abort/timeout rules.
  // halt_at/abort_at are 1-based RUN cycle numbers, 0 meaning never.
  task automatic run_prog(input string tag, input int prog, input int halt_at, input int abort_at,
                          input bit poke_init, input bit wr, input int widx,
                          input logic [PW-1:0] wpc);
    int kend;
    bit by_abort, by_halt;
    logic [PW-1:0] exp_pc;
    logic [3:0] exp_flags;
    run_state_e exp_state;

    kend = TO; by_abort = 0; by_halt = 0;
    if (halt_at > 0 && halt_at <= kend) begin kend = halt_at; by_halt = 1; end
    if (abort_at > 0 && abort_at <= kend) begin kend = abort_at; by_abort = 1; by_halt = 0; end
    exp_pc = exp_tbl[prog];

    bus.start = 1'b1;
    bus.prog_sel = IW'(prog);
    if (wr) begin
      bus.cfg_we = 1'b1; bus.cfg_idx = IW'(widx); bus.cfg_pc = wpc;
    end
    step();
    bus.start = 1'b0;
    bus.cfg_we = 1'b0;
    if (wr) exp_tbl[widx] = wpc;

    for (int t = 0; t < IC; t++) begin
      vectors++;
      if ({bus.cpu_init, bus.busy, bus.done, bus.timeout} !== 4'b1100 || bus.start_pc !== exp_pc) begin
        miscompares++;
        $display("FAIL %s init[%0d]: flags=%b pc=%h, want flags=1100 pc=%h", tag, t,
                 {bus.cpu_init, bus.busy, bus.done, bus.timeout}, bus.start_pc, exp_pc);
      end
      if (poke_init && t == 0) begin
        bus.start = 1'b1; bus.prog_sel = IW'(prog ^ 1); bus.abort = 1'b1; bus.cpu_halt = 1'b1;
      end
      step();
      bus.start = 1'b0; bus.abort = 1'b0; bus.cpu_halt = 1'b0;
    end

    for (int k = 1; k <= kend; k++) begin
      vectors++;
      if ({bus.cpu_init, bus.busy, bus.done, bus.timeout} !== 4'b0100 || bus.cycle_count !== CW'(k - 1)) begin
        miscompares++;
        $display("FAIL %s run[%0d]: flags=%b cnt=%0d, want flags=0100 cnt=%0d", tag, k,
                 {bus.cpu_init, bus.busy, bus.done, bus.timeout}, bus.cycle_count, k - 1);
      end
      bus.cpu_halt = (k == halt_at);
      bus.abort    = (k == abort_at);
      step();
      bus.cpu_halt = 1'b0;
      bus.abort    = 1'b0;
    end

    if (by_abort)     begin exp_flags = 4'b1000; exp_state = IDLE; end
    else if (by_halt) begin exp_flags = 4'b1010; exp_state = DONE; end
    else              begin exp_flags = 4'b1011; exp_state = DONE; end
    vectors++;
    if ({bus.cpu_init, bus.busy, bus.done, bus.timeout} !== exp_flags || bus.cycle_count !== CW'(kend)
        || bus.start_pc !== exp_pc || bus.dbg_state !== exp_state) begin
      miscompares++;
      $display("FAIL %s end: flags=%b cnt=%0d pc=%h st=%0d, want flags=%b cnt=%0d pc=%h st=%0d", tag,
               {bus.cpu_init, bus.busy, bus.done, bus.timeout}, bus.cycle_count, bus.start_pc,
               bus.dbg_state, exp_flags, kend, exp_pc, exp_state);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if ({bus.cpu_init, bus.busy, bus.done, bus.timeout} !== 4'b1000 || bus.cycle_count !== '0
        || bus.start_pc !== '0 || bus.dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL %s: flags=%b cnt=%0d pc=%h st=%0d, want flags=1000 cnt=0 pc=00 st=0", tag,
               {bus.cpu_init, bus.busy, bus.done, bus.timeout}, bus.cycle_count, bus.start_pc,
               bus.dbg_state);
    end
  endtask

  task automatic test_reset();
    drive_quiet();
    init = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_outputs("reset_hold");
    end
    init = 1'b0;
    for (int i = 0; i < NP; i++) exp_tbl[i] = '0;
    step();
    check_reset_outputs("reset_release");
    run_prog("reset_empty_tbl", 1, 1, 0, 0, 0, 0, '0);
  endtask

  task automatic test_normal();
    cfg_write(2, 8'h10);
    run_prog("normal", 2, 5, 0, 0, 0, 0, '0);
    // halt and abort are ignored once the run is over
    bus.cpu_halt = 1'b1; bus.abort = 1'b1;
    step();
    bus.cpu_halt = 1'b0; bus.abort = 1'b0;
    vectors++;
    if ({bus.cpu_init, bus.busy, bus.done, bus.timeout} !== 4'b1010 || bus.cycle_count !== CW'(5)
        || bus.dbg_state !== DONE) begin
      miscompares++;
      $display("FAIL done_hold: flags=%b cnt=%0d st=%0d, want flags=1010 cnt=5 st=3",
               {bus.cpu_init, bus.busy, bus.done, bus.timeout}, bus.cycle_count, bus.dbg_state);
    end
  endtask

  task automatic test_watchdog();
    run_prog("watchdog", 1, 0, 0, 0, 0, 0, '0);
    run_prog("halt_at_timeout", 2, TO, 0, 0, 0, 0, '0);
  endtask

  task automatic test_abort_restart();
    cfg_write(3, 8'h3c);
    run_prog("abort", 3, 0, 3, 0, 0, 0, '0);
    run_prog("restart_poke", 3, 6, 0, 1, 0, 0, '0);
    run_prog("abort_vs_halt", 2, 4, 4, 0, 0, 0, '0);
  endtask

  task automatic test_config_race();
    cfg_write(0, 8'h08);
    run_prog("race_old", 0, 2, 0, 0, 1, 0, 8'h20);
    run_prog("race_new", 0, 2, 0, 0, 0, 0, '0);
  endtask

  task automatic test_reset_midrun();
    bus.start = 1'b1; bus.prog_sel = IW'(2);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < IC + 3; i++) step();
    vectors++;
    if (bus.cpu_init !== 1'b0 || bus.cycle_count !== CW'(3)) begin
      miscompares++;
      $display("FAIL midrun_pre: cpu_init=%b cnt=%0d, want cpu_init=0 cnt=3", bus.cpu_init, bus.cycle_count);
    end
    init = 1'b1;
    step();
    init = 1'b0;
    for (int i = 0; i < NP; i++) exp_tbl[i] = '0;
    check_reset_outputs("midrun_reset");
    for (int p = 0; p < NP; p++) run_prog("midrun_tbl_clear", p, 0, 1, 0, 0, 0, '0);
  endtask

  task automatic test_random();
    int prog, halt_at, abort_at, widx;
    bit wr;
    logic [PW-1:0] wpc;
    for (int it = 0; it < 30; it++) begin
      for (int w = $urandom_range(0, 2); w > 0; w--)
        cfg_write($urandom_range(0, NP - 1), PW'($urandom_range(0, 255)));
      prog     = $urandom_range(0, NP - 1);
      halt_at  = $urandom_range(0, TO + 4);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 2) : 0;
      wr       = $urandom_range(0, 1);
      widx     = $urandom_range(0, NP - 1);
      wpc      = PW'($urandom_range(0, 255));
      run_prog("random", prog, halt_at, abort_at, $urandom_range(0, 1), wr, widx, wpc);
    end
  endtask

  initial begin
    init = 1'b1;
    drive_quiet();
    test_reset();
    test_normal();
    test_watchdog();
    test_abort_restart();
    test_config_race();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
